load_align_seq: RTL
===================

// Module: load_align_seq
// PURPOSE
//  Sequential load-return unit for the MEM stage. It accepts one load request,
//  issues one or two aligned bus reads, then returns aligned and extended data
//  plus per-byte GPR write enables to WB through a valid/ready pair.
//  Supports a parametrised bus width, optional split of unaligned accesses,
//  LWL/LWR merge enables, and an address-error flag. One load in flight.
// PARAMETERS
//  DATA_W      32  bus width in bits: 32 or 64; OFF_W = log2(DATA_W/8)
//  ADDR_W      32  address width
//  UNALIGN_EN  0   1: split/merge naturally-misaligned LH/LHU/LW; 0: flag error
// PORTS
//  clk             in   1       clock, rising edge
//  resetn          in   1       asynchronous, active-low reset
//  req_valid       in   1       load request valid
//  req_ready       out  1       high only in IDLE
//  req_addr        in   ADDR_W  byte address
//  req_type        in   7       one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}
//  req_wen         in   1       instruction writes GPR
//  mem_req_valid   out  1       bus read request
//  mem_req_ready   in   1       bus accepts request
//  mem_addr        out  ADDR_W  beat-aligned address (low OFF_W bits zero)
//  mem_resp_valid  in   1       read data valid
//  mem_rdata       in   DATA_W  read data, little-endian lanes
//  rsp_valid       out  1       result valid
//  rsp_ready       in   1       WB accepts result
//  rsp_data        out  32      aligned, extended data
//  rsp_byte_we     out  4       GPR byte write enables
//  rsp_addr_err    out  1       AdEL: misaligned, not serviced
// BEHAVIOUR
//  Reset: FSM=IDLE; req_ready=1; mem_req_valid=0; rsp_valid=0;
//   rsp_data=0; rsp_byte_we=0; rsp_addr_err=0; mem_addr=0.
//  FSM: IDLE -> REQ0 -> WAIT0 -> [REQ1 -> WAIT1] -> RESP -> IDLE.
//  IDLE: latch addr, type and wen on req_valid&req_ready.
//   If misaligned and UNALIGN_EN=0, go straight to RESP with err=1 and
//   byte_we=0. No bus access in that case.
//  Misaligned means: lh/lhu with addr[0]!=0, or lw with addr[1:0]!=0.
//   lb/lbu/lwl/lwr are never misaligned.
//  REQ0: mem_req_valid=1, mem_addr=addr&~(DATA_W/8-1). Hold both until
//   mem_req_ready. On the handshake, go to WAIT0.
//  WAIT0: on mem_resp_valid, capture beat0. The bus must not send a response
//   before its request handshake. mem_resp_valid is ignored outside WAIT0/WAIT1.
//  Split: needed when UNALIGN_EN=1 and off+size > DATA_W/8 (size 2 or 4 bytes).
//   Then REQ1 uses mem_addr + DATA_W/8. Byte i of the result is taken from
//   {beat1,beat0} starting at byte off. Otherwise WAIT0 -> RESP.
//  Address arithmetic on the second beat wraps modulo 2^ADDR_W.
//  Lane select: for DATA_W=64, the 32-bit word is mem_rdata[32*addr[2] +: 32].
//   b = addr[1:0] within that word.
//  Extension: lb/lbu give byte b, sign/zero-extended. lh/lhu give bytes b..b+1,
//   sign/zero-extended. lw gives the full word. byte_we = {4{wen}}.
//  LWL: data = word << 8*(3-b); byte_we = ({4{wen}} << (3-b)) & 4'hF.
//   Example: b=0 -> 4'b1000, b=3 -> 4'b1111.
//  LWR: data = word >> 8*b; byte_we = {4{wen}} >> b.
//   Example: b=0 -> 4'b1111, b=3 -> 4'b0001.
//  RESP: rsp_* are registered and held stable while rsp_valid & !rsp_ready.
//   On the handshake, go to IDLE; rsp_valid drops the next cycle.
//  Latency, aligned load with zero-wait bus: accept at T, mem_req_valid at T+1.
//   With the response at T+2, rsp_valid is at T+3.
//   Each split adds 2 cycles. The error path gives rsp_valid at T+1.
//  Throughput: one load per >= 4 cycles. req_ready=0 from acceptance until the
//   rsp handshake.
//  Reset mid-operation: immediate return to reset values. A bus response that
//   arrives later lands in IDLE and is ignored.
// TESTING
//  T1 DATA_W=32, lb @0x1003, rdata=0x80FF_1234 -> rsp_data=0xFFFF_FF80,
//     byte_we=4'hF, err=0.
//  T2 lwl @0x2000 (b=0), rdata=0xAABBCCDD, wen=1 -> data=0xDD00_0000,
//     byte_we=4'b1000. Also lwr @0x2003 -> data=0x0000_00AA, byte_we=4'b0001.
//  T3 UNALIGN_EN=0, lw @0x1002 -> no mem_req_valid, rsp_valid at T+1,
//     err=1, byte_we=0.
//  T4 UNALIGN_EN=1, DATA_W=32, lhu @0x1003: beat0=0x11223344 @0x1000,
//     beat1=0x55667788 @0x1004 -> data=0x0000_8811.
//  T5 DATA_W=64, lw @0x8004, rdata=0xDEADBEEF_01234567 -> data=0xDEADBEEF,
//     single beat.
//  T6 mem_req_ready stalled 3 cycles, then rsp_ready low 2 cycles ->
//     outputs stable throughout. Assert resetn low in WAIT0 -> IDLE; a late
//     mem_resp_valid produces no rsp_valid.

Source files
------------

// File: rtl/load_align_seq.sv
// Load-return unit for the MEM stage.
// Accepts one load, issues one or two beat-aligned bus reads, then returns
// aligned and extended data plus per-byte GPR write enables to WB.
// Only one load is in flight at a time.
module load_align_seq #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit UNALIGN_EN = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [6:0]        req_type,
  input  logic              req_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [3:0]        rsp_byte_we,
  output logic              rsp_addr_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  // req_type is one-hot {lb, lbu, lh, lhu, lw, lwl, lwr}
  state_t            state;
  logic [OFF_W-1:0]  offQ;
  logic [6:0]        typeQ;
  logic              wenQ;
  logic              splitQ;
  logic [DATA_W-1:0] beat0Q;

  logic              reqHalf;
  logic              reqWord;
  logic [OFF_W-1:0]  reqOff;
  logic              reqMisaligned;
  logic              reqSplit;

  logic [DATA_W-1:0]   beatLo;
  logic [DATA_W-1:0]   beatHi;
  logic [2*DATA_W-1:0] pairFull;
  logic [OFF_W+3:0]    winIdx;
  logic [OFF_W-1:0]    laneOff;
  logic [OFF_W+2:0]    laneIdx;
  logic [31:0]         win;
  logic [31:0]         laneWord;
  logic [1:0]          b;
  logic [31:0]         extData;
  logic [3:0]          extWe;

  assign reqHalf       = req_type[4] | req_type[3];
  assign reqWord       = req_type[2];
  assign reqOff        = req_addr[OFF_W-1:0];
  assign reqMisaligned = (reqHalf & req_addr[0]) | (reqWord & (req_addr[1:0] != 2'b00));
  assign reqSplit      = UNALIGN_EN &&
                         ((reqHalf && (int'(reqOff) + 2 > BYTES)) ||
                          (reqWord && (int'(reqOff) + 4 > BYTES)));

  // Build the result from the beat(s): sized loads read a 32-bit window of
  // {beat1,beat0} starting at the byte offset, LWL/LWR work on the 32-bit lane.
  always_comb begin
    beatLo   = (state == WAIT1) ? beat0Q : mem_rdata;
    beatHi   = (state == WAIT1) ? mem_rdata : '0;
    pairFull = {beatHi, beatLo};
    winIdx   = {1'b0, offQ, 3'b000};
    win      = pairFull[winIdx +: 32];
    laneOff  = offQ & ~OFF_W'(3);
    laneIdx  = {laneOff, 3'b000};
    laneWord = beatLo[laneIdx +: 32];
    b        = offQ[1:0];
    extData  = '0;
    extWe    = {4{wenQ}};
    if (typeQ[6]) begin
      extData = {{24{win[7]}}, win[7:0]};
    end else if (typeQ[5]) begin
      extData = {24'h0, win[7:0]};
    end else if (typeQ[4]) begin
      extData = {{16{win[15]}}, win[15:0]};
    end else if (typeQ[3]) begin
      extData = {16'h0, win[15:0]};
    end else if (typeQ[2]) begin
      extData = win;
    end else if (typeQ[1]) begin
      extData = laneWord << {~b, 3'b000};
      extWe   = {4{wenQ}} << ~b;
    end else if (typeQ[0]) begin
      extData = laneWord >> {b, 3'b000};
      extWe   = {4{wenQ}} >> b;
    end
  end

  // Control FSM with all handshake outputs and the result held in registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_byte_we   <= '0;
      rsp_addr_err  <= 1'b0;
      offQ          <= '0;
      typeQ         <= '0;
      wenQ          <= 1'b0;
      splitQ        <= 1'b0;
      beat0Q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            offQ      <= reqOff;
            typeQ     <= req_type;
            wenQ      <= req_wen;
            splitQ    <= reqSplit;
            if (reqMisaligned && !UNALIGN_EN) begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_data     <= '0;
              rsp_byte_we  <= '0;
              rsp_addr_err <= 1'b1;
            end else begin
              state         <= REQ0;
              mem_req_valid <= 1'b1;
              mem_addr      <= req_addr & ~ADDR_W'(BYTES - 1);
            end
          end
        end
        REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_resp_valid) begin
            if (splitQ) begin
              beat0Q        <= mem_rdata;
              mem_req_valid <= 1'b1;
              mem_addr      <= mem_addr + ADDR_W'(BYTES);
              state         <= REQ1;
            end else begin
              rsp_valid    <= 1'b1;
              rsp_data     <= extData;
              rsp_byte_we  <= extWe;
              rsp_addr_err <= 1'b0;
              state        <= RESP;
            end
          end
        end
        REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_resp_valid) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= extData;
            rsp_byte_we  <= extWe;
            rsp_addr_err <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
